// File: rtl/fb_write_mux.sv
// Merges several render-stage pixel streams into one VRAM write port.
// Each source has its own FIFO; a round-robin arbiter drains them while VRAM is ready.
module fb_write_mux #(
    parameter int N_SRC  = 2,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_SRC*ADDR_W-1:0]  src_addr,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    input  logic [N_SRC-1:0]         src_wr,
    input  logic                     vram_ready,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_data,
    output logic                     vram_wr,
    output logic [N_SRC-1:0]         overflow,
    output logic                     idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [N_SRC-1:0] w_nonempty;
    logic [N_SRC-1:0] w_pop;
    logic [ENT_W-1:0] w_head [N_SRC];

    logic             w_found;
    logic             w_grant;
    logic [RR_W-1:0]  w_win;
    logic [RR_W-1:0]  w_rr_next;

    logic [RR_W-1:0]   r_rr;
    logic              r_vram_wr;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_data;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_fifo
            logic [ENT_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0] r_wptr;
            logic [PTR_W-1:0] r_rptr;
            logic [PTR_W:0]   r_count;
            logic             r_ovf;
            logic             w_push;

            // A full FIFO still accepts a push when it is being popped this cycle.
            assign w_push = src_wr[gi] &&
                            ((r_count < (PTR_W+1)'(DEPTH)) || w_pop[gi]);
            assign w_nonempty[gi] = (r_count != '0);
            assign w_pop[gi]      = w_grant && (w_win == RR_W'(gi));
            assign w_head[gi]     = r_mem[r_rptr];
            assign overflow[gi]   = r_ovf;

            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wptr] <= {src_addr[gi*ADDR_W +: ADDR_W],
                                      src_data[gi*DATA_W +: DATA_W]};
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else begin
                    if (w_push)
                        r_wptr <= r_wptr + 1'b1;
                    if (w_pop[gi])
                        r_rptr <= r_rptr + 1'b1;
                    if (w_push && !w_pop[gi])
                        r_count <= r_count + 1'b1;
                    else if (!w_push && w_pop[gi])
                        r_count <= r_count - 1'b1;
                    if (src_wr[gi] && !w_push)
                        r_ovf <= 1'b1;
                end
            end
        end
    endgenerate

    // Scan rr..N_SRC-1 first, then wrap to 0..rr-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int j = 0; j < N_SRC; j++) begin
            if (!w_found && w_nonempty[j] && (RR_W'(j) >= r_rr)) begin
                w_found = 1'b1;
                w_win   = RR_W'(j);
            end
        end
        for (int j = 0; j < N_SRC; j++) begin
            if (!w_found && w_nonempty[j]) begin
                w_found = 1'b1;
                w_win   = RR_W'(j);
            end
        end
        w_grant   = w_found && vram_ready;
        w_rr_next = (w_win == RR_W'(N_SRC - 1)) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr        <= '0;
            r_vram_wr   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
        end else if (w_grant) begin
            r_rr                       <= w_rr_next;
            r_vram_wr                  <= 1'b1;
            {r_vram_addr, r_vram_data} <= w_head[w_win];
        end else begin
            r_vram_wr <= 1'b0;
        end
    end

    assign vram_wr   = r_vram_wr;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;
    assign idle      = (w_nonempty == '0) && !r_vram_wr;

endmodule
